// File: rtl/seq_div8x4_pkg.sv
// Shared constants and FSM encoding for the 8-by-4 sequential restoring divider.
package div_pkg;
   localparam int DW_N = 8;
   localparam int DW_D = 4;
   localparam logic [DW_N-1:0] DZ_QUOTIENT = 8'hFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;
endpackage

// File: rtl/seq_div8x4_if.sv
// Operand/result bus of the sequential divider, plus FSM state for observation.
interface seq_div8x4_if
   import div_pkg::*;
();
   // valid/ready: a transfer happens on a rising clk edge where both are 1; the
   // producer holds data while valid=1 and ready=0, and valid never waits on ready.
   logic            in_valid;
   logic            in_ready;
   logic [DW_N-1:0] dividend;
   logic [DW_D-1:0] divisor;
   logic            out_valid;
   logic            out_ready;
   logic [DW_N-1:0] quotient;
   logic [DW_D-1:0] remainder;
   logic            div_by_zero;
   state_t          dbg_state;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, dbg_state
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, dbg_state
   );
endinterface

// File: rtl/seq_div8x4_div_step.sv
// One restoring division step: shift in a dividend bit, then subtract the divisor if it fits.
module div_step
   import div_pkg::*;
(
   input  logic [DW_D:0]   prem_i,
   input  logic            bit_i,
   input  logic [DW_D-1:0] divisor_i,
   output logic [DW_D:0]   prem_o,
   output logic            qbit_o
);
   logic [DW_D+1:0] shifted;
   logic [DW_D:0]   diff;

   assign shifted = {prem_i, bit_i};
   assign qbit_o  = (shifted >= {2'b00, divisor_i});
   // When qbit_o is 1 the difference is below the divisor, so 5 bits suffice.
   assign diff    = shifted[DW_D:0] - {1'b0, divisor_i};
   assign prem_o  = qbit_o ? diff : shifted[DW_D:0];
endmodule

// File: rtl/seq_div8x4.sv
// 8-bit by 4-bit unsigned sequential divider: one quotient bit per cycle, MSB first.
module seq_div8x4
   import div_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   seq_div8x4_if.slave   bus
);
   state_t          state_q;
   logic [2:0]      cnt_q;
   logic [DW_N-1:0] dvd_q;
   logic [DW_D-1:0] dvs_q;
   logic [DW_D:0]   prem_q;
   logic [DW_N-2:0] qsh_q;
   logic [DW_N-1:0] quot_q;
   logic [DW_D-1:0] rem_q;
   logic            dz_q;
   logic [DW_D:0]   prem_d;
   logic            qbit_d;

   div_step u_step (
      .prem_i    (prem_q),
      .bit_i     (dvd_q[DW_N-1]),
      .divisor_i (dvs_q),
      .prem_o    (prem_d),
      .qbit_o    (qbit_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         prem_q  <= '0;
         qsh_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  dvd_q  <= bus.dividend;
                  dvs_q  <= bus.divisor;
                  prem_q <= '0;
                  qsh_q  <= '0;
                  cnt_q  <= '0;
                  if (bus.divisor == '0) begin
                     state_q <= DONE;
                     quot_q  <= DZ_QUOTIENT;
                     rem_q   <= '0;
                     dz_q    <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               dvd_q  <= {dvd_q[DW_N-2:0], 1'b0};
               prem_q <= prem_d;
               qsh_q  <= {qsh_q[DW_N-3:0], qbit_d};
               cnt_q  <= cnt_q + 3'd1;
               // The eighth step's quotient bit goes straight into the result.
               if (cnt_q == 3'd7) begin
                  state_q <= DONE;
                  quot_q  <= {qsh_q, qbit_d};
                  rem_q   <= prem_d[DW_D-1:0];
                  dz_q    <= 1'b0;
               end
            end
            DONE: begin
               if (bus.out_ready) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready    = (state_q == IDLE);
   assign bus.out_valid   = (state_q == DONE);
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dz_q;
   assign bus.dbg_state   = state_q;
endmodule

// File: doc/seq_div8x4.md
SEQ_DIV8X4 -- requirements
Module: seq_div8x4

Interface
REQ-001 Parameter: DW_N, 8, dividend and quotient width (fixed at 8 for this revision).
REQ-002 Parameter: DW_D, 4, divisor and remainder width (fixed at 4 for this revision).
REQ-003 Port: clk  input  1  single rising-edge clock for all state.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  operand pair present.
REQ-006 Port: in_ready  output  1  block can accept an operand pair.
REQ-007 Port: dividend  input  8  unsigned dividend, typically a 4x4 multiplier product.
REQ-008 Port: divisor  input  4  unsigned divisor.
REQ-009 Port: out_valid  output  1  result registers hold a valid result.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: quotient  output  8  unsigned quotient.
REQ-012 Port: remainder  output  4  unsigned remainder.
REQ-013 Port: div_by_zero  output  1  flag for the current result: divisor was 0.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept SHALL occur on a clk edge with in_valid=1 and in_ready=1; the block SHALL latch dividend and divisor on that edge.
REQ-017 On accept with divisor!=0: the FSM SHALL enter RUN, clear the 5-bit partial remainder, and load iteration counter = 0.
REQ-018 In RUN: each cycle SHALL perform one restoring step, MSB first: shift in the next dividend bit, then compare with and subtract the divisor, producing 1 quotient bit.
REQ-019 After the 8th step, the FSM SHALL go to DONE; out_valid SHALL rise 8 cycles after the accept edge.
REQ-020 On accept with divisor=0: the FSM SHALL go directly to DONE with quotient=8'hFF, remainder=4'h0, div_by_zero=1; latency SHALL be 1 cycle.
REQ-021 div_by_zero SHALL be 0 for every result with divisor!=0.
REQ-022 The result SHALL satisfy quotient*divisor + remainder = dividend, with remainder < divisor.
REQ-023 The internal partial remainder SHALL be 5 bits wide; the output remainder SHALL be its low 4 bits.
REQ-024 In DONE, quotient, remainder and div_by_zero SHALL hold stable while out_ready=0, for an unbounded stall.
REQ-025 On a DONE edge with out_ready=1, the FSM SHALL return to IDLE; the next accept SHALL be possible no earlier than the following edge.
REQ-026 Minimum issue interval SHALL be 10 cycles for divisor!=0 and 3 cycles for divisor=0.
REQ-027 in_valid asserted outside IDLE SHALL be ignored: no latch and no state change.
REQ-028 Changes on dividend/divisor after accept SHALL NOT affect the result in progress.
REQ-029 Output registers SHALL update only on the RUN-to-DONE and IDLE-to-DONE transitions.

Reset
REQ-030 On rst=1 at a clk edge, the FSM SHALL go to IDLE and the counter SHALL go to 0.
REQ-031 On rst=1 at a clk edge, quotient, remainder and div_by_zero SHALL go to 0 and out_valid SHALL go to 0.
REQ-032 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-033 rst SHALL take priority over accept, step and handshake events on the same edge.
REQ-034 rst in RUN or DONE SHALL abort the operation; no out_valid pulse for the aborted operation SHALL follow.

Structure
REQ-035 Shared package div_pkg SHALL hold: the state enum (IDLE, RUN, DONE), the DW_N/DW_D constants, and the div-by-zero quotient constant 8'hFF.
REQ-036 The combinational sub-module div_step SHALL implement one restoring step.
REQ-037 div_step inputs SHALL be the 5-bit partial remainder, 1 dividend bit and the 4-bit divisor.
REQ-038 div_step outputs SHALL be the next partial remainder and 1 quotient bit.
REQ-039 The top level SHALL hold only the FSM, counter, shift registers and output registers.

Verification
REQ-040 Basic: 225/15 with out_ready=1 -> quotient=15, remainder=0, div_by_zero=0; out_valid exactly 8 cycles after accept.
REQ-041 Remainder: 200/7 -> quotient=28, remainder=4; then 60/6 -> quotient=10, remainder=0; second in_ready rises one cycle after first handshake.
REQ-042 Div-by-zero: 37/0 -> quotient=8'hFF, remainder=0, div_by_zero=1, out_valid 1 cycle after accept.
REQ-043 Backpressure: 45/9 with out_ready=0 for 20 cycles -> quotient=5, remainder=0, held stable; in_ready=0 throughout; in_valid pulses ignored.
REQ-044 Reset mid-op: rst at cycle 4 of RUN for 255/1 -> outputs 0, in_ready=1 next cycle, no stray out_valid; then 15/15 -> 1, remainder 0.
REQ-045 Exhaustive check: all 256x16 operand pairs -> compared against reference division; errors reported with the operands.
